// File: rtl/fifo_ui_pkg.sv
// Shared types and defaults for the FIFO demo push-button front end.
package fifo_ui_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_HOLD = 2'd1,
    RD_HOLD = 2'd2
  } ui_state_e;

  typedef enum logic {
    GRANT_WR = 1'b0,
    GRANT_RD = 1'b1
  } grant_e;

  localparam int REPEAT_DELAY_DEF = 64;
  localparam int REPEAT_RATE_DEF  = 16;

endpackage

// File: rtl/btn_edge_detect.sv
// Rising-edge detector for a debounced button level; the history register
// resets high so a button held through reset produces no event.
module btn_edge_detect (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic btn_i,
  output logic rise_o
);

  logic btn_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) btn_q <= 1'b1;
    else          btn_q <= btn_i;
  end

  assign rise_o = btn_i & ~btn_q;

endmodule

// File: rtl/fifo_button_ctrl.sv
// Turns write/read button levels into guarded single-cycle FIFO strobes with
// tie arbitration and auto-repeat while a button is held.
module fifo_button_ctrl
  import fifo_ui_pkg::*;
#(
  parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE  = REPEAT_RATE_DEF,
  parameter int CNT_W        = 8
) (
  input  logic clk_from_divider,
  input  logic rst_n,
  input  logic wr_btn,
  input  logic rd_btn,
  input  logic fifo_full,
  input  logic fifo_empty,
  output logic wr_en,
  output logic rd_en,
  output logic ovf_err,
  output logic udf_err,
  output logic busy
);

  localparam logic [CNT_W-1:0] DELAY_LD = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LD  = CNT_W'(REPEAT_RATE - 1);

  logic wr_rise, rd_rise;

  btn_edge_detect u_wr_edge (
    .clk_i  (clk_from_divider),
    .rst_n_i(rst_n),
    .btn_i  (wr_btn),
    .rise_o (wr_rise)
  );

  btn_edge_detect u_rd_edge (
    .clk_i  (clk_from_divider),
    .rst_n_i(rst_n),
    .btn_i  (rd_btn),
    .rise_o (rd_rise)
  );

  ui_state_e        state_q, state_d;
  grant_e           last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic             ovf_q, ovf_d, udf_q, udf_d, busy_q, busy_d;
  logic             do_wr, do_rd;

  always_ff @(posedge clk_from_divider or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_RD;
      cnt_q        <= '0;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      wr_en_q      <= wr_en_d;
      rd_en_q      <= rd_en_d;
      ovf_q        <= ovf_d;
      udf_q        <= udf_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    do_wr        = 1'b0;
    do_rd        = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A tie goes to the side that did not win the previous tie.
        if (wr_rise && rd_rise) begin
          if (last_grant_q == GRANT_RD) begin
            do_wr        = 1'b1;
            last_grant_d = GRANT_WR;
          end else begin
            do_rd        = 1'b1;
            last_grant_d = GRANT_RD;
          end
        end else if (wr_rise) begin
          do_wr = 1'b1;
        end else if (rd_rise) begin
          do_rd = 1'b1;
        end
        if (do_wr) begin
          state_d = WR_HOLD;
          cnt_d   = DELAY_LD;
        end else if (do_rd) begin
          state_d = RD_HOLD;
          cnt_d   = DELAY_LD;
        end
      end
      WR_HOLD: begin
        if (!wr_btn) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          do_wr = 1'b1;
          cnt_d = RATE_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RD_HOLD: begin
        if (!rd_btn) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          do_rd = 1'b1;
          cnt_d = RATE_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    wr_en_d = do_wr & ~fifo_full;
    ovf_d   = do_wr &  fifo_full;
    rd_en_d = do_rd & ~fifo_empty;
    udf_d   = do_rd &  fifo_empty;
    busy_d  = (state_d != IDLE);
  end

  assign wr_en   = wr_en_q;
  assign rd_en   = rd_en_q;
  assign ovf_err = ovf_q;
  assign udf_err = udf_q;
  assign busy    = busy_q;

endmodule

// File: doc/fifo_button_ctrl.md
# fifo_button_ctrl

Converts the debounced write and read push-button levels into single-cycle FIFO write/read enables for the FIFO demo design. It sits between the two button debouncers and the FIFO, and runs on the divided clock `clk_from_divider`. It provides:
- edge detection on each button;
- round-robin arbitration when both buttons are pressed together;
- auto-repeat while a button is held;
- full/empty guarding, with error pulses for refused requests.

## Interface
Parameters:
- `REPEAT_DELAY`, default 64: `clk_from_divider` cycles from the initial enable pulse to the first auto-repeat pulse. Must be ≥ 2.
- `REPEAT_RATE`, default 16: cycles between subsequent auto-repeat pulses. Must be ≥ 2.
- `CNT_W`, default 8: width of the repeat counter. Must satisfy 2^CNT_W > max(`REPEAT_DELAY`, `REPEAT_RATE`).

Ports:
- `clk_from_divider`  in  1  block clock (divided clock, shared with the debouncers).
- `rst_n`  in  1  asynchronous active-low reset.
- `wr_btn`  in  1  debounced write-button level, active-high.
- `rd_btn`  in  1  debounced read-button level, active-high.
- `fifo_full`  in  1  FIFO full flag, synchronous to `clk_from_divider`.
- `fifo_empty`  in  1  FIFO empty flag, synchronous to `clk_from_divider`.
- `wr_en`  out  1  one-cycle FIFO write strobe.
- `rd_en`  out  1  one-cycle FIFO read strobe.
- `ovf_err`  out  1  one-cycle pulse: a write attempt was refused because the FIFO was full.
- `udf_err`  out  1  one-cycle pulse: a read attempt was refused because the FIFO was empty.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- Edge detect:
  - `wr_q`/`rd_q` register the previous button levels.
  - Rise = level & ~q.
  - `wr_q` and `rd_q` reset to 1, so a button held through reset generates no event.
- FSM states: IDLE, WR_HOLD, RD_HOLD.
  - **IDLE, wr rise only:** write attempt, go to WR_HOLD.
  - **IDLE, rd rise only:** read attempt, go to RD_HOLD.
  - **IDLE, both rise in the same cycle:** grant the side opposite `last_grant`, then toggle `last_grant`. The losing press is discarded and must be released and re-pressed.
  - **WR_HOLD / RD_HOLD:** stay while the owning button is high. Return to IDLE in the first cycle the owning button is sampled low. Edges on the other button in these states are discarded.
- Attempt, resolved in a single cycle:
  - Write: if `fifo_full` = 0, pulse `wr_en`; otherwise pulse `ovf_err` and leave `wr_en` at 0.
  - Read: if `fifo_empty` = 0, pulse `rd_en`; otherwise pulse `udf_err` and leave `rd_en` at 0.
  - The flags used are the values sampled at the attempt edge.
- Auto-repeat:
  - An initial attempt loads the counter with `REPEAT_DELAY`-1.
  - In a HOLD state the counter decrements once per cycle.
  - When the counter is 0 and the button is still high, make a repeat attempt and reload `REPEAT_RATE`-1.
  - A refused attempt still reloads the counter, so repeats continue while the button is held.
- `last_grant` resets to "read", so the first tie is granted to write.
- Reset (async, at any time including mid-hold or mid-pulse):
  - state = IDLE, counter = 0;
  - `wr_en` = `rd_en` = `ovf_err` = `udf_err` = `busy` = 0;
  - `wr_q` = `rd_q` = 1.
- `wr_en` and `rd_en` are never high in the same cycle. An error pulse and its matching enable are never high in the same cycle.

## Timing
- All outputs are registered.
- Latency: the button is first sampled high at edge k; the output is high for exactly the one cycle after edge k.
- Repeat pulse spacing:
  - initial pulse to first repeat: exactly `REPEAT_DELAY` cycles;
  - each later repeat: `REPEAT_RATE` cycles.
- Release:
  - Button sampled low at edge k: no attempt is made at edge k, and the state is IDLE after edge k.
  - A rise sampled at edge k+1 is accepted.
- Release and a repeat due in the same cycle: release wins, no pulse.
- `busy` rises with the first enable/error pulse and falls one cycle after the release is sampled.

## Structure
- Package `fifo_ui_pkg`:
  - FSM state enum (IDLE, WR_HOLD, RD_HOLD);
  - default constants for `REPEAT_DELAY` and `REPEAT_RATE`;
  - grant encoding (GRANT_WR, GRANT_RD).
- Sub-module `btn_edge_detect`:
  - one register with reset value 1;
  - outputs a rise pulse;
  - instantiated once for `wr_btn` and once for `rd_btn`.
- The counter, arbitration and FSM stay in `fifo_button_ctrl`.

## Test plan
- **Single write press:**
  - stimulus: `fifo_full`=0; `wr_btn` high 10 cycles, then low (`REPEAT_DELAY`=64);
  - required: exactly one `wr_en` pulse, 1 cycle after the rise is sampled; `busy` drops after release.
- **Auto-repeat:**
  - stimulus: `wr_btn` held 100 cycles (`REPEAT_DELAY`=64, `REPEAT_RATE`=16);
  - required: `wr_en` pulses at relative cycles 0, 64, 80, 96, so 4 pulses in total.
- **Tie arbitration:**
  - stimulus: both buttons rise together after reset; release both; press both again;
  - required: first tie gives `wr_en` only, second tie gives `rd_en` only.
- **Guarding:**
  - stimulus: `rd_btn` press with `fifo_empty`=1; `wr_btn` press with `fifo_full`=1;
  - required: `udf_err` 1-cycle pulse with `rd_en`=0; `ovf_err` 1-cycle pulse with `wr_en`=0.
- **Reset mid-hold:**
  - stimulus: assert `rst_n`=0 during WR_HOLD with `wr_btn` still high; release reset while `wr_btn` stays high;
  - required: all outputs 0 immediately; no `wr_en` until `wr_btn` goes low and rises again.
- **Cross-press ignored:**
  - stimulus: `rd_btn` rises during WR_HOLD, then `wr_btn` is released while `rd_btn` stays high;
  - required: no `rd_en` until `rd_btn` is released and re-pressed.
